// File: rtl/qpp_ind_gen.sv
// qpp_ind_gen -- QPP interleaver index generator.
//
// Emits, per block, every sequential index i = 0..K-1 together with its
// interleaved index pi(i) = (F1*i + F2*i^2) mod K. The quadratic is evaluated
// incrementally with two modular adders, so no multipliers are needed:
//   pi(i+1) = pi(i) + g(i),   g(i+1) = g(i) + 2*F2,   g(0) = F1 + F2  (all mod K)
// Two block-size modes, each with its own K/F1/F2 set, are selected per block.
//
// Ports:
//   clock    in   rising-edge clock
//   reset    in   synchronous active-high reset, returns to IDLE
//   start    in   launch a block (honoured only in IDLE)
//   k        in   mode select, sampled together with start
//   ready    in   downstream accepts the current pair this cycle
//   valid    out  seq_idx/int_idx hold a valid pair
//   seq_idx  out  sequential index i
//   int_idx  out  interleaved index pi(i)
//   last     out  valid pair is the final one of the block (i = K-1)
//   busy     out  high while the block is in RUN or DONE
//   done     out  one-cycle pulse after the final pair is accepted

module qpp_ind_gen #(
   parameter int W    = 14,
   parameter int K0   = 1056,
   parameter int F1_0 = 17,
   parameter int F2_0 = 66,
   parameter int K1   = 6144,
   parameter int F1_1 = 263,
   parameter int F2_1 = 480
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         start,
   input  logic         k,
   input  logic         ready,
   output logic         valid,
   output logic [W-1:0] seq_idx,
   output logic [W-1:0] int_idx,
   output logic         last,
   output logic         busy,
   output logic         done
);

   // K can equal 2^W, so the modulus needs one extra bit.
   localparam logic [W:0]   K0_M    = (W+1)'(K0);
   localparam logic [W:0]   K1_M    = (W+1)'(K1);
   localparam logic [W-1:0] LAST0   = W'(K0 - 1);
   localparam logic [W-1:0] LAST1   = W'(K1 - 1);
   localparam logic [W-1:0] G0_INIT = W'((F1_0 + F2_0) % K0);
   localparam logic [W-1:0] G1_INIT = W'((F1_1 + F2_1) % K1);
   localparam logic [W-1:0] STEP0   = W'((2 * F2_0) % K0);
   localparam logic [W-1:0] STEP1   = W'((2 * F2_1) % K1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DONE
   } state_t;

   state_t       state;
   logic         mode;
   logic [W-1:0] seq;
   logic [W-1:0] pi;
   logic [W-1:0] g;

   // Modular add for operands already reduced below m: a single
   // conditional subtract brings the (W+1)-bit sum back into range.
   function automatic logic [W-1:0] mod_add(input logic [W-1:0] a,
                                            input logic [W-1:0] b,
                                            input logic [W:0]   m);
      logic [W:0] sum;
      // NOTE: blocking assignments are correct here: this is a local
      // temporary evaluated in order, not a state register.
      sum = {1'b0, a} + {1'b0, b};
      if (sum >= m) sum = sum - m;
      return sum[W-1:0];
   endfunction

   // Per-block constants follow the latched mode, never the live k input.
   logic [W:0]   k_cur;
   logic [W-1:0] last_cur;
   logic [W-1:0] step_cur;
   logic [W-1:0] pi_next;
   logic [W-1:0] g_next;

   assign k_cur    = mode ? K1_M  : K0_M;
   assign last_cur = mode ? LAST1 : LAST0;
   assign step_cur = mode ? STEP1 : STEP0;
   assign pi_next  = mod_add(pi, g, k_cur);
   assign g_next   = mod_add(g, step_cur, k_cur);

   always_ff @(posedge clock) begin
      // NOTE: every state register uses non-blocking assignment so all of
      // them update together from the pre-edge values.
      if (reset) begin
         state <= S_IDLE;
         mode  <= 1'b0;
         seq   <= '0;
         pi    <= '0;
         g     <= '0;
         valid <= 1'b0;
         busy  <= 1'b0;
         done  <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  state <= S_RUN;
                  mode  <= k;
                  seq   <= '0;
                  pi    <= '0;
                  g     <= k ? G1_INIT : G0_INIT;
                  valid <= 1'b1;
                  busy  <= 1'b1;
               end
            end
            S_RUN: begin
               if (ready) begin
                  if (seq == last_cur) begin
                     // Clear the index path so nothing stale survives
                     // into the next block or shows on idle outputs.
                     state <= S_DONE;
                     seq   <= '0;
                     pi    <= '0;
                     g     <= '0;
                     valid <= 1'b0;
                     done  <= 1'b1;
                  end else begin
                     seq <= seq + W'(1);
                     pi  <= pi_next;
                     g   <= g_next;
                  end
               end
            end
            S_DONE: begin
               state <= S_IDLE;
               busy  <= 1'b0;
               done  <= 1'b0;
            end
            default: begin
               state <= S_IDLE;
               valid <= 1'b0;
               busy  <= 1'b0;
               done  <= 1'b0;
            end
         endcase
      end
   end

   assign seq_idx = seq;
   assign int_idx = pi;
   assign last    = valid & (seq == last_cur);

endmodule

// File: tb/tb_qpp_ind_gen.sv
// tb_qpp_ind_gen -- scoreboard bench for qpp_ind_gen.
//
// Stimulus pushes each block's expected pairs (closed-form QPP) into a
// queue; a negedge monitor pops one entry per accepted pair and compares,
// also checking hand-computed values, stall stability and mode-1 permutation.

module tb_qpp_ind_gen;

   localparam int W    = 14;
   localparam int K0   = 1056;
   localparam int F1_0 = 17;
   localparam int F2_0 = 66;
   localparam int K1   = 6144;
   localparam int F1_1 = 263;
   localparam int F2_1 = 480;

   logic         clock = 1'b0;
   logic         reset;
   logic         start;
   logic         k;
   logic         ready;
   logic         valid;
   logic [W-1:0] seq_idx;
   logic [W-1:0] int_idx;
   logic         last;
   logic         busy;
   logic         done;

   qpp_ind_gen #(
      .W(W), .K0(K0), .F1_0(F1_0), .F2_0(F2_0),
      .K1(K1), .F1_1(F1_1), .F2_1(F2_1)
   ) dut (
      .clock(clock), .reset(reset), .start(start), .k(k), .ready(ready),
      .valid(valid), .seq_idx(seq_idx), .int_idx(int_idx), .last(last),
      .busy(busy), .done(done)
   );

   always #5 clock = ~clock;

   typedef struct {
      int seq;
      int idx;
      bit lst;
   } pair_t;

   pair_t  exp_q[$];
   int     n_checks = 0;
   int     n_fail   = 0;
   int     cyc      = 0;
   int     t0       = 0;
   int     cur_k    = K0;
   bit     cur_mode = 1'b0;
   int     stall_cnt = 0;
   int     done_cnt  = 0;
   bit     chk_done  = 1'b0;
   bit     held_valid = 1'b0;
   int     held_seq;
   int     held_int;
   bit     seen [0:(1<<W)-1];
   int     dup_cnt = 0;
   int     hand0 [int];
   int     hand1 [int];

   always @(posedge clock) cyc <= cyc + 1;

   task automatic check(input string name, input longint act, input longint exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic int qpp(input int kk, input int f1, input int f2, input int i);
      longint li;
      li = i;
      return int'((longint'(f1) * li + longint'(f2) * li * li) % kk);
   endfunction

   // Monitor: sampled on the falling edge, away from the active edge.
   always @(negedge clock) begin
      if (valid) begin
         if (held_valid) begin
            check("stall_seq_stable", seq_idx, held_seq);
            check("stall_int_stable", int_idx, held_int);
         end
         if (ready) begin
            held_valid = 1'b0;
            if (exp_q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL unexpected_pair: got seq %0d int %0d with empty scoreboard",
                        seq_idx, int_idx);
            end else begin
               pair_t e;
               e = exp_q.pop_front();
               check("seq_idx", seq_idx, e.seq);
               check("int_idx", int_idx, e.idx);
               check("last", last, e.lst);
               if (!cur_mode && hand0.exists(int'(seq_idx)))
                  check("hand_mode0", int_idx, hand0[int'(seq_idx)]);
               if (cur_mode && hand1.exists(int'(seq_idx)))
                  check("hand_mode1", int_idx, hand1[int'(seq_idx)]);
               if (cur_mode) begin
                  if (seen[int_idx]) dup_cnt++;
                  seen[int_idx] = 1'b1;
               end
            end
         end else begin
            held_valid = 1'b1;
            held_seq   = seq_idx;
            held_int   = int_idx;
            stall_cnt++;
         end
      end else begin
         held_valid = 1'b0;
      end
      if (done) done_cnt++;
   end

   // Call at posedge+1; leaves the bench at posedge+1 after the start edge.
   task automatic issue_start(input bit m);
      if (chk_done) check("done_pulse_count", done_cnt, 1);
      done_cnt  = 0;
      chk_done  = 1'b1;
      stall_cnt = 0;
      cur_mode  = m;
      cur_k     = m ? K1 : K0;
      for (int i = 0; i < cur_k; i++) begin
         pair_t p;
         p.seq = i;
         p.idx = m ? qpp(K1, F1_1, F2_1, i) : qpp(K0, F1_0, F2_0, i);
         p.lst = (i == cur_k - 1);
         exp_q.push_back(p);
      end
      if (m) begin
         for (int i = 0; i < (1<<W); i++) seen[i] = 1'b0;
         dup_cnt = 0;
      end
      start = 1'b1;
      k     = m;
      @(posedge clock);
      #1;
      t0    = cyc;
      start = 1'b0;
      check("start_valid", valid, 1);
      check("start_busy", busy, 1);
      check("start_seq", seq_idx, 0);
      check("start_int", int_idx, 0);
   endtask

   // Runs the current block to its done pulse; returns at posedge+1 in DONE.
   task automatic run_to_done(input bit rnd, input int poke_at);
      int done_at;
      bit poked;
      done_at = -1;
      poked   = 1'b0;
      for (int c = 0; c < 20000; c++) begin
         @(posedge clock);
         #1;
         start = 1'b0;
         if (done) begin
            done_at = cyc;
            break;
         end
         if (poke_at >= 0 && !poked && valid && int'(seq_idx) == poke_at) begin
            start = 1'b1;
            k     = ~k;
            poked = 1'b1;
         end
         if (rnd) ready = ($urandom_range(0, 1) == 1);
      end
      ready = 1'b1;
      if (done_at < 0) begin
         n_checks++;
         n_fail++;
         $display("FAIL done_timeout: no done within cycle budget (mode %0d)", cur_mode);
      end else begin
         check("done_cycle", done_at, t0 + cur_k + stall_cnt);
         check("done_valid_low", valid, 0);
      end
      check("scoreboard_drained", exp_q.size(), 0);
   endtask

   task automatic check_perm();
      int cnt;
      cnt = 0;
      for (int i = 0; i < (1<<W); i++) if (seen[i]) cnt++;
      check("perm_count", cnt, K1);
      check("perm_dups", dup_cnt, 0);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      hand0[0] = 0;  hand0[1] = 83;  hand0[2] = 298;
      hand0[3] = 645; hand0[4] = 68; hand0[1055] = 49;
      hand1[1] = 743; hand1[2] = 2446; hand1[6143] = 217;

      reset = 1'b1;
      start = 1'b0;
      k     = 1'b0;
      ready = 1'b1;
      repeat (3) @(posedge clock);
      #1;
      check("rst_valid", valid, 0);
      check("rst_seq", seq_idx, 0);
      check("rst_int", int_idx, 0);
      check("rst_last", last, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      reset = 1'b0;

      // Mode 0, ready held high.
      issue_start(1'b0);
      run_to_done(1'b0, -1);

      // Mode 1 back-to-back, start on the first IDLE cycle.
      @(posedge clock);
      #1;
      issue_start(1'b1);
      run_to_done(1'b0, -1);
      check_perm();

      // Mode 0 with random backpressure.
      @(posedge clock);
      #1;
      issue_start(1'b0);
      run_to_done(1'b1, -1);

      // start + k toggle at i=100 must not restart or change mode.
      @(posedge clock);
      #1;
      issue_start(1'b0);
      run_to_done(1'b0, 100);

      // start in the DONE cycle is ignored; one cycle later it is accepted.
      start = 1'b1;
      k     = 1'b0;
      @(posedge clock);
      #1;
      check("done_start_ignored_busy", busy, 0);
      check("done_start_ignored_valid", valid, 0);
      issue_start(1'b0);
      run_to_done(1'b0, -1);

      // Reset mid-block at i=500, with start asserted to show reset wins.
      @(posedge clock);
      #1;
      issue_start(1'b0);
      begin
         bit hit;
         hit = 1'b0;
         for (int c = 0; c < 2000; c++) begin
            if (valid && seq_idx == W'(500)) begin
               hit = 1'b1;
               break;
            end
            @(posedge clock);
            #1;
         end
         if (!hit) begin
            n_checks++;
            n_fail++;
            $display("FAIL reach_i500_timeout: seq_idx never reached 500");
         end
      end
      reset = 1'b1;
      start = 1'b1;
      @(posedge clock);
      #1;
      reset = 1'b0;
      start = 1'b0;
      check("midrst_valid", valid, 0);
      check("midrst_seq", seq_idx, 0);
      check("midrst_int", int_idx, 0);
      check("midrst_last", last, 0);
      check("midrst_busy", busy, 0);
      check("midrst_done", done, 0);
      exp_q.delete();
      chk_done   = 1'b0;
      held_valid = 1'b0;
      issue_start(1'b0);
      run_to_done(1'b0, -1);

      @(posedge clock);
      #1;
      check("final_done_pulse_count", done_cnt, 1);
      check("final_done_low", done, 0);
      check("final_busy_low", busy, 0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
